// File: rtl/timer_io_ctrl.sv
// Timer configuration port decoder and timer_end interrupt controller.
// Holds umbral/basetiempo, restarts the timer on reconfiguration and raises a four-phase irq.
module timer_io_ctrl #(
    parameter int          ADDR_W     = 4,
    parameter int unsigned TIMER_PORT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [7:0]        io_wdata,
    input  logic              timer_end,
    output logic [5:0]        umbral,
    output logic [1:0]        basetiempo,
    output logic              timer_rst,
    output logic              irq,
    input  logic              irq_ack,
    output logic [3:0]        missed
);

    localparam logic [ADDR_W-1:0] PORT_ADDR = ADDR_W'(TIMER_PORT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [3:0] sat_inc(input logic [3:0] value);
        if (value == 4'd15) begin
            sat_inc = 4'd15;
        end else begin
            sat_inc = value + 4'd1;
        end
    endfunction

    logic [5:0] umbral_r;
    logic [1:0] basetiempo_r;
    logic       timer_rst_r;
    logic       irq_r;
    logic [3:0] missed_r;
    logic       sync1_r;
    logic       sync2_r;
    logic       prev_r;
    logic [1:0] blank_cnt_r;
    state_t     state_r;

    logic       cfg_wr_s;
    logic       edge_s;
    logic       enabled_s;
    logic       event_s;
    state_t     state_nxt_s;
    logic [3:0] missed_nxt_s;
    logic       irq_nxt_s;

    assign cfg_wr_s  = io_we && (io_addr == PORT_ADDR);
    assign edge_s    = sync2_r && !prev_r;
    assign enabled_s = (umbral_r != 6'd0);
    // The write cycle itself and the blanking window both discard edges left in the synchronizer.
    assign event_s   = edge_s && enabled_s && (blank_cnt_r == 2'd0) && !cfg_wr_s;

    // Configuration register, restart pulse and blanking counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            umbral_r     <= 6'd0;
            basetiempo_r <= 2'd0;
            timer_rst_r  <= 1'b0;
            blank_cnt_r  <= 2'd0;
        end else begin
            timer_rst_r <= cfg_wr_s;
            if (cfg_wr_s) begin
                umbral_r     <= io_wdata[7:2];
                basetiempo_r <= io_wdata[1:0];
                blank_cnt_r  <= 2'd3;
            end else if (blank_cnt_r != 2'd0) begin
                blank_cnt_r <= blank_cnt_r - 2'd1;
            end else begin
                blank_cnt_r <= 2'd0;
            end
        end
    end

    // Two-flop synchronizer for timer_end followed by the edge-detect history flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= timer_end;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Interrupt FSM state and its registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            irq_r    <= 1'b0;
            missed_r <= 4'd0;
        end else begin
            state_r  <= state_nxt_s;
            irq_r    <= irq_nxt_s;
            missed_r <= missed_nxt_s;
        end
    end

    // Next-state, irq and missed-event counter logic.
    always_comb begin
        state_nxt_s  = state_r;
        missed_nxt_s = missed_r;
        irq_nxt_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (event_s) begin
                    state_nxt_s = ST_PEND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (cfg_wr_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (irq_ack) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_PEND;
                end
            end
            ST_DONE: begin
                // A write here does not cancel the handshake; wait for the ack to drop.
                if (!irq_ack) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        if (cfg_wr_s) begin
            missed_nxt_s = 4'd0;
        end else if (event_s && (state_r != ST_IDLE)) begin
            missed_nxt_s = sat_inc(missed_r);
        end else begin
            missed_nxt_s = missed_r;
        end

        if (state_nxt_s == ST_PEND) begin
            irq_nxt_s = 1'b1;
        end else begin
            irq_nxt_s = 1'b0;
        end
    end

    assign umbral     = umbral_r;
    assign basetiempo = basetiempo_r;
    assign timer_rst  = timer_rst_r;
    assign irq        = irq_r;
    assign missed     = missed_r;

endmodule

// File: doc/timer_io_ctrl.md
# timer_io_ctrl

I/O-side controller for the programmable timer. It decodes CPU output writes to the timer configuration port and holds `umbral` and `basetiempo` for the timer. It also takes back the timer's `timer_end` and turns it into an interrupt request with a four-phase acknowledge handshake. It sits between the CPU I/O bus and the timer, and drives the timer's configuration inputs.

## Interface
Parameters:
- `ADDR_W`, default 4: width of the CPU I/O port address.
- `TIMER_PORT`, default 4: port address of the timer configuration register.

Ports:
- `clk`  in  1: system clock; all logic is on the rising edge. Only clock.
- `reset`  in  1: asynchronous, active-high reset.
- `io_we`  in  1: CPU output-write strobe, one cycle per write.
- `io_addr`  in  ADDR_W: CPU output port address.
- `io_wdata`  in  8: CPU output data. Bits [7:2] are the threshold, bits [1:0] are the time base.
- `timer_end`  in  1: end-of-count level from the timer. It may change relative to `clk` at any time and is synchronized internally.
- `umbral`  out  6: threshold for the timer (registered).
- `basetiempo`  out  2: time-base select for the timer (registered).
- `timer_rst`  out  1: one-cycle pulse that restarts the timer after reconfiguration.
- `irq`  out  1: interrupt request to the CPU.
- `irq_ack`  in  1: interrupt acknowledge from the CPU (level, four-phase).
- `missed`  out  4: saturating count of timer events lost while an interrupt was outstanding.

## Operation
- **Config write:** `io_we && io_addr == TIMER_PORT`. On that edge:
  - `umbral <= io_wdata[7:2]`, `basetiempo <= io_wdata[1:0]`.
  - `timer_rst` is high for exactly the next cycle.
  - `missed` clears to 0.
  - Writes to other addresses are ignored.
- **Enable:** the timer is enabled when `umbral != 0`. While disabled, events are ignored and `missed` does not count.
- **Event detection:**
  - `timer_end` passes through a 2-flop synchronizer, then a rising-edge detector (previous-value register).
  - An event is a detected rising edge.
  - Levels held high produce one event only.
- **Blanking:** a 2-bit counter loads 3 on a config write and decrements to 0. Events are discarded while the counter is non-zero and in the write cycle itself. This flushes stale edges out of the synchronizer.
- **Interrupt FSM**, states IDLE, PEND, DONE:
  - IDLE, on an enabled, unblanked event → PEND.
  - PEND (`irq = 1`), on `irq_ack = 1` → DONE.
  - DONE (`irq = 0`), on `irq_ack = 0` → IDLE.
  - `irq_ack` seen in IDLE is ignored.
- **Missed events:** an enabled, unblanked event in PEND or DONE increments `missed`, saturating at 15, with no other effect.
- **Config write while in PEND:** FSM → IDLE and `irq` drops.
- **Config write while in DONE:** FSM stays in DONE, waiting for `irq_ack` low.
- **Simultaneous config write and event:** the write wins and the event is discarded.
- **Simultaneous `irq_ack` rise and event in PEND:** go to DONE and `missed` increments.

## Timing
- **Reset values:** `umbral = 0`, `basetiempo = 0`, `timer_rst = 0`, `irq = 0`, `missed = 0`, FSM = IDLE. Synchronizer, edge, and blanking registers are all 0.
- **Reset mid-operation:** all state returns to reset values immediately (asynchronous).
- **Configuration latency:** `umbral`/`basetiempo` take the new value on the edge that samples the write. `timer_rst` is high during the following cycle only.
- **Event latency:** let E0 be the first `clk` edge sampling `timer_end = 1`. `irq` is high after edge E0+2, i.e. 3 registered stages (sync1, sync2, FSM).
- **Ack latency:** `irq` falls 1 edge after `irq_ack` is sampled high. FSM reaches IDLE 1 edge after `irq_ack` is sampled low. A new event is accepted in the following cycle.
- **Back-to-back writes:** each write reloads the blanking counter and re-pulses `timer_rst`. Consecutive write cycles keep `timer_rst` high continuously.

## Test plan
- **Reset, then config:** write 0xB5 to port 4 → `umbral = 45`, `basetiempo = 1` on the next cycle, `timer_rst` high for 1 cycle, `irq = 0`, `missed = 0`.
- **Wrong port:** write 0xFF to port 3 → all outputs unchanged, no `timer_rst`.
- **Event and handshake:** `umbral = 45`; raise `timer_end` at edge E0 → `irq = 1` after E0+2. Raise `irq_ack` → `irq = 0` next cycle. Drop `irq_ack`, then give a second event → `irq` re-asserts with the same latency.
- **Missed counting:** hold `irq` pending, give 17 `timer_end` pulses (each high ≥3 cycles and low ≥3 cycles) → `missed` = 15 (saturated). A config write then clears it to 0 and drops `irq`.
- **Disabled and blanking:**
  - Write 0x00 then pulse `timer_end` → no `irq`, `missed = 0`.
  - Write 0x14 one cycle before `timer_end` rises → that event is discarded.
  - The next pulse after the blanking window raises `irq`.
- **Async reset:** assert `reset` for 1 ns while in PEND with `missed = 3` → all outputs return to reset values immediately, with no `clk` edge needed.
